// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encoding, word width and reset PC for the fetch stage
package fetch_pkg;
    localparam int WORD_W = 32;
    localparam logic [WORD_W-1:0] PC_RESET_DEF = 32'h0000_3000;
    typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;
endpackage

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: F-stage PC sequencer with IM handshake, hold register and delay-slot redirects (FETCH_ALIGN_CHK_EN adds f_adel)
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [WORD_W-1:0] PC_RESET = PC_RESET_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [WORD_W-1:0] redirect_pc,
    output logic              im_req,
    output logic [WORD_W-1:0] im_addr,
    input  logic              im_ack,
    input  logic [WORD_W-1:0] im_rdata,
    output logic              f_valid,
    output logic [WORD_W-1:0] f_pc,
    output logic [WORD_W-1:0] f_instr
`ifdef FETCH_ALIGN_CHK_EN
    ,
    output logic              f_adel
`endif
);
    state_t            state, state_nx;
    logic [WORD_W-1:0] pc, pend_pc;
    logic              pend_v, accept, redir, misal, done;

    // Handshake decode and next-state; im_req depends on registered state only
    always_comb begin
`ifdef FETCH_ALIGN_CHK_EN
        misal = pc[1:0] != 2'b00;
`else
        misal = 1'b0;
`endif
        accept   = state == HOLD && !stall;
        redir    = redirect_valid && !stall;
        done     = state == FETCH && (im_ack || misal);
        im_req   = state == FETCH && !misal;
        im_addr  = pc;
        state_nx = state == IDLE ? FETCH :
                   state == FETCH ? (done ? HOLD : FETCH) :
                   (accept ? FETCH : HOLD);
    end

    // PC, pending-target and hold-register updates; the instruction in flight or held is the delay slot
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            pc      <= PC_RESET;
            pend_pc <= '0;
            pend_v  <= 1'b0;
            f_valid <= 1'b0;
            f_pc    <= '0;
            f_instr <= '0;
`ifdef FETCH_ALIGN_CHK_EN
            f_adel  <= 1'b0;
`endif
        end else begin
            state <= state_nx;
            if (done) begin
                f_valid <= 1'b1;
                f_pc    <= pc;
                f_instr <= misal ? '0 : im_rdata;
`ifdef FETCH_ALIGN_CHK_EN
                f_adel  <= misal;
`endif
            end else if (accept) begin
                f_valid <= 1'b0;
                pc      <= redir ? redirect_pc : pend_v ? pend_pc : pc + 32'd4;
                pend_v  <= 1'b0;
`ifdef FETCH_ALIGN_CHK_EN
                f_adel  <= 1'b0;
`endif
            end
            if (redir && state != HOLD) begin
                pend_v  <= 1'b1;
                pend_pc <= redirect_pc;
            end
        end
    end
endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Fetch-stage sequencer for the five-stage MIPS pipeline. Owns the F-stage PC register, drives a request/acknowledge handshake to a variable-latency instruction memory, and holds the fetched instruction until D accepts it. Applies D-stage redirects (branch/j/jal/jr/jalr targets) with MIPS delay-slot semantics, so the next-address selection feeds this block.

## Interface
- `PC_RESET`, default 32'h0000_3000: first fetch address after reset.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `stall`  in  1  D stage stalled; the held instruction is not accepted.
- `redirect_valid`  in  1  D instruction resolves a taken control transfer.
- `redirect_pc`  in  32  target address for that transfer.
- `im_req`  out  1  instruction-memory request.
- `im_addr`  out  32  request address (= current PC).
- `im_ack`  in  1  memory returns data this cycle; may be asserted in the same cycle as `im_req`.
- `im_rdata`  in  32  instruction word, valid with `im_ack`.
- `f_valid`  out  1  `f_instr`/`f_pc` hold a fetched instruction.
- `f_pc`  out  32  address of the held instruction.
- `f_instr`  out  32  held instruction word.

## Operation
- States: IDLE, FETCH, HOLD.
- IDLE: reset state. Goes to FETCH on the first edge after reset deasserts.
- FETCH: `im_req`=1 and `im_addr`=pc. Both stay stable until `im_ack`. There is no abort. On `im_ack`, the block latches `im_rdata`→`f_instr` and pc→`f_pc`, sets `f_valid`, and goes to HOLD.
- HOLD: `im_req`=0 and `f_valid`=1.
  - Accept is `stall`=0. On accept, `f_valid` clears, the state goes to FETCH, and pc loads the next address.
  - Next address, in priority order: `redirect_pc` if `redirect_valid` is sampled in the same cycle; else the pending target if one is pending; else pc+4.
- Redirect sampling: `redirect_valid` is sampled only when `stall`=0. A stalled D instruction's redirect is not final and is ignored.
- Delay slot: a redirect never squashes the instruction in flight (FETCH) or held (HOLD). That instruction is the delay slot. The target applies to the fetch that follows it.
- Redirect during FETCH, or during HOLD without accept: the block stores `pend_pc`=`redirect_pc` and sets `pend_v`=1. A later redirect before consumption overwrites it (newest wins).
- `pend_v` clears when the pending target is loaded into pc.
- Arithmetic: pc+4 is unsigned and wraps mod 2^32. Targets are taken verbatim.

## Timing
- Reset values: `im_req`=0, `im_addr`=`PC_RESET`, `f_valid`=0, `f_pc`=0, `f_instr`=0. Internally pc=`PC_RESET` and `pend_v`=0.
- `im_req` is decoded from the state register only, so it is glitch-free.
- Fetch latency: with `im_ack` in request cycle N, `f_valid` is 1 from cycle N+1.
- Peak throughput: one instruction per 2 cycles (zero-wait memory).
- Accept at edge E: `im_req` is high at the new PC from the cycle after E.
- Reset asserted mid-request: `im_req` drops immediately (asynchronous). The outstanding request is abandoned, and the memory must tolerate this.

## Configuration
- `FETCH_ALIGN_CHK_EN` defined:
  - An extra output `f_adel` (1 bit, reset 0) is present.
  - When FETCH starts with pc[1:0]≠0, the block issues no request (`im_req`=0).
  - The next cycle it enters HOLD with `f_instr`=32'h0, `f_pc`=pc and `f_adel`=1.
  - `f_adel` clears on accept.
- `FETCH_ALIGN_CHK_EN` undefined: no `f_adel` port, and misaligned addresses are requested as-is.

## Structure
- Shared package `fetch_pkg` holds:
  - the state encoding (IDLE/FETCH/HOLD, 2 bits);
  - the `PC_RESET` default constant;
  - the width constant for the 32-bit address/instruction words.
- Single module. The next-address priority mux stays inline; no sub-module is warranted.

## Test plan
- Reset release with `im_ack` tied high, `stall`=0: `im_addr` runs 0x3000, 0x3004, 0x3008, with `f_valid` pulsing every other cycle.
- `im_ack` delayed 3 cycles: `im_req`/`im_addr`=0x3000 stay stable for 4 cycles. `f_valid` rises the cycle after ack.
- Branch case:
  - Stimulus: `redirect_valid`=1 with `redirect_pc`=0x3100 while fetching 0x3008.
  - Required: 0x3008 is delivered (delay slot), then `im_addr`=0x3100. Addresses 0x300C and beyond are never requested.
- `stall`=1 for 5 cycles in HOLD (`f_pc`=0x3004): `f_valid`, `f_instr` and `f_pc` stay constant. `redirect_valid` pulsed during the stall is ignored, and the next fetch is 0x3008.
- Two redirects:
  - Stimulus: redirect to 0x4000, then to 0x5000, both before the held instruction is accepted.
  - Required: the next fetch after accept is 0x5000.
- Redirect and accept in the same cycle (`redirect_pc`=0x3200): the next `im_addr` is 0x3200. With `FETCH_ALIGN_CHK_EN`, redirect to 0x3202 gives `f_adel`=1, `f_instr`=0 and no `im_req`.
